// File: rtl/axis_reg_slice.sv
// AXI4-Stream register slice with three build-time flavours:
//   MODE 0: wires only, MODE 1: single forward register,
//   MODE 2: two-entry skid buffer with a registered s_tready.
// Beat and packet counters observe transfers on the m_ side in every mode.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 8,
    parameter int MODE       = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [1:0]              occupancy,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    beat_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 m_xfer;
    logic [CNT_WIDTH-1:0] pkt_count_reg;
    logic [CNT_WIDTH-1:0] beat_count_reg;

    assign m_xfer     = m_tvalid && m_tready;
    assign pkt_count  = pkt_count_reg;
    assign beat_count = beat_count_reg;

    // Free-running counters of downstream beats and packets; wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_reg  <= '0;
            beat_count_reg <= '0;
        end else if (m_xfer) begin
            beat_count_reg <= beat_count_reg + CNT_ONE;
            if (m_tlast) begin
                pkt_count_reg <= pkt_count_reg + CNT_ONE;
            end
        end
    end

    generate
        if (MODE == 0) begin : g_bypass
            assign m_tdata   = s_tdata;
            assign m_tkeep   = s_tkeep;
            assign m_tlast   = s_tlast;
            assign m_tvalid  = s_tvalid;
            assign s_tready  = m_tready;
            assign occupancy = 2'd0;
        end else if (MODE == 1) begin : g_forward
            logic [DATA_WIDTH-1:0] data_reg;
            logic [KEEP_WIDTH-1:0] keep_reg;
            logic                  last_reg;
            logic                  valid_reg;

            // Accept whenever the register is empty or drains this cycle.
            assign s_tready  = !reset && (!valid_reg || m_tready);
            assign m_tdata   = data_reg;
            assign m_tkeep   = keep_reg;
            assign m_tlast   = last_reg;
            assign m_tvalid  = valid_reg;
            assign occupancy = {1'b0, valid_reg};

            // Output register: load on upstream transfer, clear when drained.
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg  <= '0;
                    keep_reg  <= '0;
                    last_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end else if (s_tvalid && s_tready) begin
                    data_reg  <= s_tdata;
                    keep_reg  <= s_tkeep;
                    last_reg  <= s_tlast;
                    valid_reg <= 1'b1;
                end else if (m_tready) begin
                    valid_reg <= 1'b0;
                end
            end
        end else begin : g_skid
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                FULL  = 2'd2
            } state_t;

            state_t                state_reg;
            state_t                state_next;
            logic                  ready_reg;
            logic                  s_xfer;
            logic                  load_from_in;
            logic                  load_from_skid;
            logic                  load_skid;
            logic [DATA_WIDTH-1:0] out_data_reg;
            logic [KEEP_WIDTH-1:0] out_keep_reg;
            logic                  out_last_reg;
            logic [DATA_WIDTH-1:0] skid_data_reg;
            logic [KEEP_WIDTH-1:0] skid_keep_reg;
            logic                  skid_last_reg;

            assign s_tready  = ready_reg;
            assign s_xfer    = s_tvalid && ready_reg;
            assign m_tvalid  = (state_reg != EMPTY);
            assign m_tdata   = out_data_reg;
            assign m_tkeep   = out_keep_reg;
            assign m_tlast   = out_last_reg;
            assign occupancy = state_reg;

            // State register plus registered ready derived from the next state.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= EMPTY;
                    ready_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    ready_reg <= (state_next != FULL);
                end
            end

            // Next-state and datapath steering decisions.
            always_comb begin
                state_next     = state_reg;
                load_from_in   = 1'b0;
                load_from_skid = 1'b0;
                load_skid      = 1'b0;
                case (state_reg)
                    EMPTY: begin
                        if (s_xfer) begin
                            load_from_in = 1'b1;
                            state_next   = ONE;
                        end
                    end
                    ONE: begin
                        if (s_xfer && m_xfer) begin
                            load_from_in = 1'b1;
                        end else if (s_xfer) begin
                            load_skid  = 1'b1;
                            state_next = FULL;
                        end else if (m_xfer) begin
                            state_next = EMPTY;
                        end
                    end
                    FULL: begin
                        // ready is low here, so no upstream beat can arrive.
                        if (m_xfer) begin
                            load_from_skid = 1'b1;
                            state_next     = ONE;
                        end
                    end
                    default: begin
                        state_next = EMPTY;
                    end
                endcase
            end

            // Output and skid payload registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_data_reg  <= '0;
                    out_keep_reg  <= '0;
                    out_last_reg  <= 1'b0;
                    skid_data_reg <= '0;
                    skid_keep_reg <= '0;
                    skid_last_reg <= 1'b0;
                end else begin
                    if (load_from_in) begin
                        out_data_reg <= s_tdata;
                        out_keep_reg <= s_tkeep;
                        out_last_reg <= s_tlast;
                    end else if (load_from_skid) begin
                        out_data_reg <= skid_data_reg;
                        out_keep_reg <= skid_keep_reg;
                        out_last_reg <= skid_last_reg;
                    end
                    if (load_skid) begin
                        skid_data_reg <= s_tdata;
                        skid_keep_reg <= s_tkeep;
                        skid_last_reg <= s_tlast;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_axis_reg_slice.sv
// Directed checks of the three slice flavours plus a randomized MODE 1 run.
module tb_axis_reg_slice;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // MODE 2 instance (a_)
    logic        rst2;
    logic [7:0]  a_s_tdata, a_m_tdata;
    logic [0:0]  a_s_tkeep, a_m_tkeep;
    logic        a_s_tlast, a_s_tvalid, a_s_tready;
    logic        a_m_tlast, a_m_tvalid, a_m_tready;
    logic [1:0]  a_occ;
    logic [15:0] a_pkt, a_beat;

    // MODE 1 instance (b_)
    logic        rst1;
    logic [7:0]  b_s_tdata, b_m_tdata;
    logic [0:0]  b_s_tkeep, b_m_tkeep;
    logic        b_s_tlast, b_s_tvalid, b_s_tready;
    logic        b_m_tlast, b_m_tvalid, b_m_tready;
    logic [1:0]  b_occ;
    logic [15:0] b_pkt, b_beat;

    // MODE 0 instance (c_)
    logic        rst0;
    logic [31:0] c_s_tdata, c_m_tdata;
    logic [3:0]  c_s_tkeep, c_m_tkeep;
    logic        c_s_tlast, c_s_tvalid, c_s_tready;
    logic        c_m_tlast, c_m_tvalid, c_m_tready;
    logic [1:0]  c_occ;
    logic [15:0] c_pkt, c_beat;

    axis_reg_slice #(.DATA_WIDTH(8), .MODE(2), .CNT_WIDTH(16)) u2 (
        .clk(clk), .reset(rst2),
        .s_tdata(a_s_tdata), .s_tkeep(a_s_tkeep), .s_tlast(a_s_tlast),
        .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
        .m_tdata(a_m_tdata), .m_tkeep(a_m_tkeep), .m_tlast(a_m_tlast),
        .m_tvalid(a_m_tvalid), .m_tready(a_m_tready),
        .occupancy(a_occ), .pkt_count(a_pkt), .beat_count(a_beat)
    );

    axis_reg_slice #(.DATA_WIDTH(8), .MODE(1), .CNT_WIDTH(16)) u1 (
        .clk(clk), .reset(rst1),
        .s_tdata(b_s_tdata), .s_tkeep(b_s_tkeep), .s_tlast(b_s_tlast),
        .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
        .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep), .m_tlast(b_m_tlast),
        .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
        .occupancy(b_occ), .pkt_count(b_pkt), .beat_count(b_beat)
    );

    axis_reg_slice #(.DATA_WIDTH(32), .MODE(0), .CNT_WIDTH(16)) u0 (
        .clk(clk), .reset(rst0),
        .s_tdata(c_s_tdata), .s_tkeep(c_s_tkeep), .s_tlast(c_s_tlast),
        .s_tvalid(c_s_tvalid), .s_tready(c_s_tready),
        .m_tdata(c_m_tdata), .m_tkeep(c_m_tkeep), .m_tlast(c_m_tlast),
        .m_tvalid(c_m_tvalid), .m_tready(c_m_tready),
        .occupancy(c_occ), .pkt_count(c_pkt), .beat_count(c_beat)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] d4 [4];
    logic [0:0] k4 [4];
    logic       l4 [4];

    // MODE 1 scoreboard state: {keep, last, data}
    logic [9:0] q [$];
    logic [9:0] cur, hold, exp_beat;
    logic       stalled;
    int         sent, recv, cyc, exp_pkts;

    initial begin
        d4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        k4 = '{1'b1, 1'b0, 1'b1, 1'b1};
        l4 = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst2 = 1'b1; rst1 = 1'b1; rst0 = 1'b1;
        a_s_tdata = '0; a_s_tkeep = '0; a_s_tlast = 1'b0; a_s_tvalid = 1'b0; a_m_tready = 1'b0;
        b_s_tdata = '0; b_s_tkeep = '0; b_s_tlast = 1'b0; b_s_tvalid = 1'b0; b_m_tready = 1'b0;
        c_s_tdata = 32'hDEADBEEF; c_s_tkeep = 4'hF; c_s_tlast = 1'b1; c_s_tvalid = 1'b1; c_m_tready = 1'b1;
        repeat (3) step();

        // Reset state of the registered modes
        check("m2_rst_mvalid", a_m_tvalid, 0);
        check("m2_rst_mdata",  a_m_tdata, 0);
        check("m2_rst_mkeep",  a_m_tkeep, 0);
        check("m2_rst_mlast",  a_m_tlast, 0);
        check("m2_rst_sready", a_s_tready, 0);
        check("m2_rst_occ",    a_occ, 0);
        check("m2_rst_pkt",    a_pkt, 0);
        check("m2_rst_beat",   a_beat, 0);
        check("m1_rst_mvalid", b_m_tvalid, 0);
        check("m1_rst_sready", b_s_tready, 0);
        check("m1_rst_occ",    b_occ, 0);
        // MODE 0 keeps passing data while reset only holds the counters
        check("m0_rst_pass",   c_m_tdata, 32'hDEADBEEF);
        check("m0_rst_sready", c_s_tready, 1);
        check("m0_rst_beat",   c_beat, 0);

        rst2 = 1'b0; rst1 = 1'b0; rst0 = 1'b0;
        #1;
        check("m1_sready_first", b_s_tready, 1);
        check("m2_sready_first", a_s_tready, 0);
        step();
        c_s_tvalid = 1'b0;
        check("m2_sready_second", a_s_tready, 1);
        check("m0_beat_after1", c_beat, 1);
        check("m0_pkt_after1",  c_pkt, 1);

        // MODE 0: ready and payload follow with zero latency
        c_m_tready = 1'b0; #1;
        check("m0_sready_lo", c_s_tready, 0);
        c_m_tready = 1'b1; #1;
        check("m0_sready_hi", c_s_tready, 1);
        c_s_tdata = 32'h12345678; c_s_tkeep = 4'b0101; c_s_tvalid = 1'b1; #1;
        check("m0_mdata",  c_m_tdata, 32'h12345678);
        check("m0_mkeep",  c_m_tkeep, 4'b0101);
        check("m0_mvalid", c_m_tvalid, 1);
        check("m0_occ",    c_occ, 0);
        c_s_tvalid = 1'b0;

        // MODE 2 back-to-back burst with downstream always ready
        a_m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_s_tvalid = 1'b1; a_s_tdata = d4[i]; a_s_tkeep = k4[i]; a_s_tlast = l4[i];
            check("m2_burst_sready", a_s_tready, 1);
            step();
            check("m2_burst_mvalid", a_m_tvalid, 1);
            check("m2_burst_mdata",  a_m_tdata, d4[i]);
            check("m2_burst_mkeep",  a_m_tkeep, k4[i]);
            check("m2_burst_mlast",  a_m_tlast, l4[i]);
        end
        a_s_tvalid = 1'b0;
        step();
        check("m2_burst_drain", a_m_tvalid, 0);
        check("m2_burst_beat",  a_beat, 4);
        check("m2_burst_pkt",   a_pkt, 1);

        // MODE 2 backpressure: fill both entries, third beat waits upstream
        a_m_tready = 1'b0;
        a_s_tvalid = 1'b1; a_s_tdata = 8'hA1; a_s_tkeep = 1'b1; a_s_tlast = 1'b0;
        step();
        check("m2_bp_occ1",   a_occ, 1);
        check("m2_bp_mdata1", a_m_tdata, 8'hA1);
        check("m2_bp_sready1", a_s_tready, 1);
        a_s_tdata = 8'hA2;
        step();
        check("m2_bp_occ2",   a_occ, 2);
        check("m2_bp_sready2", a_s_tready, 0);
        check("m2_bp_mdata2", a_m_tdata, 8'hA1);
        a_s_tdata = 8'hA3; a_s_tlast = 1'b1;
        step();
        check("m2_bp_hold_occ",   a_occ, 2);
        check("m2_bp_hold_mdata", a_m_tdata, 8'hA1);
        check("m2_bp_hold_sready", a_s_tready, 0);
        a_m_tready = 1'b1;
        step();
        check("m2_bp_out_a2",  a_m_tdata, 8'hA2);
        check("m2_bp_occ_rel", a_occ, 1);
        check("m2_bp_sready_rel", a_s_tready, 1);
        step();
        check("m2_bp_out_a3",  a_m_tdata, 8'hA3);
        check("m2_bp_last_a3", a_m_tlast, 1);
        a_s_tvalid = 1'b0;
        step();
        check("m2_bp_drain", a_m_tvalid, 0);
        check("m2_bp_beat",  a_beat, 7);
        check("m2_bp_pkt",   a_pkt, 2);

        // MODE 2 reset while full discards held beats
        a_m_tready = 1'b0;
        a_s_tvalid = 1'b1; a_s_tdata = 8'hB1; a_s_tlast = 1'b0;
        step();
        a_s_tdata = 8'hB2;
        step();
        check("m2_pre_rst_occ", a_occ, 2);
        a_s_tvalid = 1'b0;
        rst2 = 1'b1;
        step();
        check("m2_mid_rst_mvalid", a_m_tvalid, 0);
        check("m2_mid_rst_occ",    a_occ, 0);
        check("m2_mid_rst_beat",   a_beat, 0);
        check("m2_mid_rst_pkt",    a_pkt, 0);
        check("m2_mid_rst_sready", a_s_tready, 0);
        rst2 = 1'b0;
        a_m_tready = 1'b1;
        step();
        check("m2_post_rst_sready", a_s_tready, 1);
        check("m2_post_rst_mvalid", a_m_tvalid, 0);
        a_s_tvalid = 1'b1; a_s_tdata = 8'hC1; a_s_tlast = 1'b0;
        step();
        check("m2_post_rst_first", a_m_tdata, 8'hC1);
        check("m2_post_rst_valid", a_m_tvalid, 1);
        a_s_tvalid = 1'b0;
        step();
        check("m2_post_rst_beat", a_beat, 1);

        // Packet counter wrap from all ones
        force u2.pkt_count_reg = 16'hFFFF;
        #1;
        check("m2_forced_pkt", a_pkt, 16'hFFFF);
        release u2.pkt_count_reg;
        a_s_tvalid = 1'b1; a_s_tdata = 8'hD1; a_s_tlast = 1'b1;
        step();
        a_s_tvalid = 1'b0;
        check("m2_wrap_pre", a_pkt, 16'hFFFF);
        step();
        check("m2_wrap_pkt",  a_pkt, 0);
        check("m2_wrap_beat", a_beat, 2);

        // MODE 1 random traffic with scoreboard and stall stability
        sent = 0; recv = 0; cyc = 0; exp_pkts = 0; stalled = 1'b0; hold = '0;
        cur = 10'($urandom);
        while (recv < 1000 && cyc < 20000) begin
            if (stalled) begin
                check("m1_stall_valid", b_m_tvalid, 1);
                check("m1_stall_payload", {b_m_tkeep, b_m_tlast, b_m_tdata}, hold);
            end
            b_s_tvalid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            b_m_tready = ($urandom_range(0, 1) == 1);
            {b_s_tkeep, b_s_tlast, b_s_tdata} = cur;
            #1;
            if (b_m_tvalid && b_m_tready) begin
                exp_beat = (q.size() > 0) ? q.pop_front() : 10'bx;
                check("m1_scoreboard", {b_m_tkeep, b_m_tlast, b_m_tdata}, exp_beat);
                recv++;
                if (exp_beat[8] === 1'b1) exp_pkts++;
            end
            if (b_s_tvalid && b_s_tready) begin
                q.push_back(cur);
                sent++;
                cur = 10'($urandom);
            end
            stalled = b_m_tvalid && !b_m_tready;
            hold = {b_m_tkeep, b_m_tlast, b_m_tdata};
            step();
            cyc++;
        end
        b_s_tvalid = 1'b0;
        check("m1_recv_total", recv, 1000);
        check("m1_beat_count", b_beat, 1000);
        check("m1_pkt_count",  b_pkt, exp_pkts);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_reg_slice.md
AXIS_REG_SLICE -- requirements
Module: axis_reg_slice

Interface
REQ-001 Parameter DATA_WIDTH, 8: tdata width in bits; legal values are multiples of 8 from 8 to 512.
REQ-002 Parameter MODE, 2: 0 = combinational bypass, 1 = forward register, 2 = full skid buffer.
REQ-003 Parameter CNT_WIDTH, 32: width of the packet and beat counters.
REQ-004 Port clk, input, 1: single clock; every register is updated on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port s_tdata, input, DATA_WIDTH: upstream payload.
REQ-007 Port s_tkeep, input, DATA_WIDTH/8: upstream byte enables.
REQ-008 Port s_tlast, input, 1: upstream end of packet.
REQ-009 Port s_tvalid, input, 1: upstream valid.
REQ-010 Port s_tready, output, 1: upstream ready.
REQ-011 Ports m_tdata, m_tkeep, m_tlast: outputs, same widths as the s_ ports, downstream payload.
REQ-012 Port m_tvalid, output, 1: downstream valid.
REQ-013 Port m_tready, input, 1: downstream ready.
REQ-014 Port occupancy, output, 2: number of beats held, 0..2.
REQ-015 Port pkt_count, output, CNT_WIDTH: packets completed on the m_ side.
REQ-016 Port beat_count, output, CNT_WIDTH: beats transferred on the m_ side.

Function
REQ-017 A transfer occurs on a side only in a cycle where its tvalid and tready are both 1; no other cycle is a transfer.
REQ-018 Beats leave the block in the order they arrived, with no loss and no duplication, and tdata, tkeep and tlast stay together.
REQ-019 While m_tvalid=1 and m_tready=0, m_tvalid and the m_ payload hold their values.
REQ-020 m_tvalid does not depend combinationally on m_tready in MODE 1 and MODE 2.
REQ-021 MODE 0 connects m_* directly to s_* and s_tready directly to m_tready; latency is 0 cycles and occupancy stays 0.
REQ-022 MODE 1 holds a single output register:
- s_tready = !m_tvalid || m_tready (combinational);
- latency is 1 cycle;
- throughput is 1 beat per cycle when m_tready is held at 1.
REQ-023 MODE 2 state machine, states EMPTY, ONE and FULL (occupancy 0, 1 and 2):
- s_tready is a registered signal, equal to 1 exactly when the state is not FULL;
- EMPTY goes to ONE on an s_ transfer;
- ONE goes to FULL on an s_ transfer with no m_ transfer;
- ONE goes to EMPTY on an m_ transfer with no s_ transfer;
- ONE stays in ONE when an s_ transfer and an m_ transfer happen in the same cycle;
- FULL goes to ONE on an m_ transfer, and the skid entry moves to the output register;
- FULL never accepts a beat.
REQ-024 MODE 2 latency is 1 cycle from an s_ transfer to m_tvalid=1; sustained throughput is 1 beat per cycle.
REQ-025 beat_count increments by 1 on each m_ transfer.
REQ-026 pkt_count increments by 1 on each m_ transfer with m_tlast=1.
REQ-027 Both counters wrap modulo 2^CNT_WIDTH from all ones to 0 without saturating.
REQ-028 A beat with tkeep=0 is still a transfer; the block never inspects or alters tkeep.
REQ-029 When s_ and m_ transfers occur in the same cycle in FULL (MODE 2), the m_ transfer is performed and the s_ side is blocked because s_tready=0.

Reset
REQ-030 While reset=1, in MODE 1 and MODE 2:
- m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0;
- s_tready=0, occupancy=0;
- pkt_count=0, beat_count=0.
REQ-031 After reset is deasserted, s_tready=1 in the first cycle (MODE 1) or one cycle later (MODE 2).
REQ-032 Reset asserted mid-packet discards every held beat and counter value; after reset no beat from before the reset appears on the m_ side.
REQ-033 In MODE 0, reset clears only the counters.

Verification
REQ-034 MODE=2, m_tready=1, drive 4 beats 0x11..0x44 back to back with tlast on 0x44 -> output in order 1 cycle later with no gaps; pkt_count=1, beat_count=4.
REQ-035 MODE=2, m_tready=0, drive beats 0xA1, 0xA2, 0xA3 -> 0xA1 and 0xA2 accepted, occupancy=2, s_tready=0 in the next cycle, 0xA3 held upstream; release m_tready -> 0xA1, 0xA2, 0xA3 delivered in order.
REQ-036 MODE=1, random s_tvalid and m_tready at 50 % for 1000 beats -> scoreboard matches, m_ payload stable during every stall.
REQ-037 Preload pkt_count to all ones via a force, send one tlast beat -> pkt_count=0.
REQ-038 MODE=2 at occupancy=2, assert reset for 1 cycle -> m_tvalid=0, occupancy=0, the first output after reset is the first beat sent after reset.
REQ-039 MODE=0, DATA_WIDTH=32, toggle m_tready -> s_tready equals m_tready in the same cycle, zero latency.
